// File: rtl/branch_predictor_if.sv
// branch_predictor_if
//  Groups the lookup, pipeline-control and training signals of the branch
//  predictor into one bundle.
//  master : pipeline side. It drives stall, flush, lookup_pc and upd_* and
//           receives the pred_* outputs.
//  slave  : predictor side.
// Ports
//  stall, flush             pipeline hold / MEM redirect
//  lookup_pc                PC_next presented to the I_Cache
//  pred_hit/taken/target    registered prediction for the PC now in IF
//  upd_valid/is_br/is_j     resolved control instruction in MEM
//  upd_taken/pc/target      outcome, PC and actual target of that instruction
interface branch_predictor_if #(
   parameter int unsigned XLEN = 32
);
   logic            stall;
   logic            flush;
   logic [XLEN-1:0] lookup_pc;
   logic            pred_hit;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            upd_valid;
   logic            upd_is_br;
   logic            upd_is_j;
   logic            upd_taken;
   logic [XLEN-1:0] upd_pc;
   logic [XLEN-1:0] upd_target;

   modport master (
      output stall, flush, lookup_pc,
      output upd_valid, upd_is_br, upd_is_j, upd_taken, upd_pc, upd_target,
      input  pred_hit, pred_taken, pred_target
   );

   modport slave (
      input  stall, flush, lookup_pc,
      input  upd_valid, upd_is_br, upd_is_j, upd_taken, upd_pc, upd_target,
      output pred_hit, pred_taken, pred_target
   );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor
//  Direct-mapped BTB with a saturating direction counter per entry. The PC
//  being fetched (PC_next) is looked up each cycle and the prediction is
//  registered so that it lines up with PC_IF, like the synchronous I_Cache
//  read. Entries are trained by resolved branches/jumps from MEM.
// Ports
//  clk    rising-edge clock
//  reset  asynchronous active-low reset; clears table and outputs
//  bus    branch_predictor_if.slave (lookup, stall/flush, training)
// Parameters
//  XLEN     address/target width
//  ENTRIES  table entries (power of 2, >= 2)
//  TAG_W    tag bits, taken from pc[IDX_W+TAG_W+1:IDX_W+2]
//  CTR_W    direction counter width (>= 1)
module branch_predictor #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ENTRIES = 64,
   parameter int unsigned TAG_W   = 8,
   parameter int unsigned CTR_W   = 2
) (
   input logic                clk,
   input logic                reset,
   branch_predictor_if.slave  bus
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_LO = IDX_W + 2;
   localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;

   // Fresh allocations start weakly taken.
   localparam logic [CTR_W-1:0] CtrWeakTaken = CTR_W'(1) << (CTR_W - 1);

   // Table storage
   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [XLEN-1:0]  target_q [ENTRIES];
   logic             is_j_q   [ENTRIES];
   logic [CTR_W-1:0] ctr_q    [ENTRIES];

   // Registered prediction
   logic            pred_hit_q;
   logic            pred_taken_q;
   logic [XLEN-1:0] pred_target_q;

   // Lookup side
   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;
   logic             lk_taken;
   logic [XLEN-1:0]  lk_target;

   // Update side
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_en;
   logic             upd_hit;
   logic             upd_tkn;
   logic [CTR_W-1:0] ctr_cur;
   logic [CTR_W-1:0] ctr_nxt;

   // pc[1:0] and the bits above the tag never take part in indexing.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.lookup_pc[XLEN-1:TAG_HI+1],
                             bus.upd_pc[1:0], bus.upd_pc[XLEN-1:TAG_HI+1]};

   // ---------------------------------------------------------------------------
   // Lookup: reads the table as it stands before this edge's update, so a
   // same-cycle lookup/update to one index sees the old contents.
   // ---------------------------------------------------------------------------
   always_comb begin
      lk_idx    = bus.lookup_pc[IDX_W+1:2];
      lk_tag    = bus.lookup_pc[TAG_HI:TAG_LO];
      lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      lk_taken  = lk_hit && (is_j_q[lk_idx] || ctr_q[lk_idx][CTR_W-1]);
      lk_target = target_q[lk_idx];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pred_hit_q    <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
      end else begin
         if (bus.flush) begin
            // Flush wins over stall for the direction outputs.
            pred_hit_q   <= 1'b0;
            pred_taken_q <= 1'b0;
         end else if (!bus.stall) begin
            pred_hit_q   <= lk_hit;
            pred_taken_q <= lk_taken;
         end
         if (!bus.stall) begin
            pred_target_q <= lk_target;
         end
      end
   end

   assign bus.pred_hit    = pred_hit_q;
   assign bus.pred_taken  = pred_taken_q;
   assign bus.pred_target = pred_target_q;

   // ---------------------------------------------------------------------------
   // Update decode. A jump (including is_br & is_j together) is always taken.
   // ---------------------------------------------------------------------------
   always_comb begin
      upd_idx = bus.upd_pc[IDX_W+1:2];
      upd_tag = bus.upd_pc[TAG_HI:TAG_LO];
      upd_en  = bus.upd_valid && (bus.upd_is_br || bus.upd_is_j);
      upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
      upd_tkn = bus.upd_is_j || bus.upd_taken;
      ctr_cur = ctr_q[upd_idx];
      ctr_nxt = ctr_cur;
      if (bus.upd_taken) begin
         if (ctr_cur != '1) ctr_nxt = ctr_cur + CTR_W'(1);
      end else begin
         if (ctr_cur != '0) ctr_nxt = ctr_cur - CTR_W'(1);
      end
   end

   // Training is never gated by stall or flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            is_j_q[i]   <= 1'b0;
            ctr_q[i]    <= '0;
         end
      end else if (upd_en) begin
         if (upd_hit) begin
            if (bus.upd_is_j) begin
               is_j_q[upd_idx]   <= 1'b1;
               target_q[upd_idx] <= bus.upd_target;
            end else begin
               ctr_q[upd_idx] <= ctr_nxt;
               if (bus.upd_taken) target_q[upd_idx] <= bus.upd_target;
            end
         end else if (upd_tkn) begin
            // Miss and taken: overwrite whatever occupies this index.
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= bus.upd_target;
            is_j_q[upd_idx]   <= bus.upd_is_j;
            ctr_q[upd_idx]    <= CtrWeakTaken;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   branch_predictor_if #(.XLEN(32)) bp_if ();

   branch_predictor #(
      .XLEN    (32),
      .ENTRIES (64),
      .TAG_W   (8),
      .CTR_W   (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bp_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic update(input logic [31:0] pc, input logic is_br, input logic is_j,
                         input logic taken, input logic [31:0] target);
      bp_if.upd_valid  = 1'b1;
      bp_if.upd_is_br  = is_br;
      bp_if.upd_is_j   = is_j;
      bp_if.upd_taken  = taken;
      bp_if.upd_pc     = pc;
      bp_if.upd_target = target;
      step();
      bp_if.upd_valid  = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] pc);
      bp_if.lookup_pc = pc;
      step();
   endtask

   task automatic expect_pred(input string tag, input logic hit, input logic taken,
                              input logic [31:0] target);
      check({tag, ".hit"}, {31'd0, bp_if.pred_hit}, {31'd0, hit});
      check({tag, ".taken"}, {31'd0, bp_if.pred_taken}, {31'd0, taken});
      check({tag, ".target"}, bp_if.pred_target, target);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b0;
      bp_if.stall      = 1'b0;
      bp_if.flush      = 1'b0;
      bp_if.lookup_pc  = 32'h0;
      bp_if.upd_valid  = 1'b0;
      bp_if.upd_is_br  = 1'b0;
      bp_if.upd_is_j   = 1'b0;
      bp_if.upd_taken  = 1'b0;
      bp_if.upd_pc     = 32'h0;
      bp_if.upd_target = 32'h0;
      step();
      step();
      expect_pred("reset_state", 1'b0, 1'b0, 32'h0);
      reset = 1'b1;
      step();

      // Allocate on a taken-branch miss, then hit.
      update(32'h100, 1'b1, 1'b0, 1'b1, 32'h40);
      lookup(32'h100);
      expect_pred("alloc", 1'b1, 1'b1, 32'h40);

      // Counter: 2 -> 1 -> 0 -> 0 -> 1 (not taken), then 2, 3, 3, then 2.
      update(32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
      lookup(32'h100);
      expect_pred("ctr1", 1'b1, 1'b0, 32'h40);
      update(32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
      update(32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
      update(32'h100, 1'b1, 1'b0, 1'b1, 32'h40);
      lookup(32'h100);
      expect_pred("sat_low", 1'b1, 1'b0, 32'h40);
      update(32'h100, 1'b1, 1'b0, 1'b1, 32'h40);
      update(32'h100, 1'b1, 1'b0, 1'b1, 32'h40);
      update(32'h100, 1'b1, 1'b0, 1'b1, 32'h48);
      lookup(32'h100);
      expect_pred("sat_high", 1'b1, 1'b1, 32'h48);
      update(32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
      lookup(32'h100);
      expect_pred("from_sat", 1'b1, 1'b1, 32'h48);

      // Alias: 0x200 shares index 0 with 0x100 but has another tag.
      lookup(32'h200);
      check("alias_miss.hit", {31'd0, bp_if.pred_hit}, 32'd0);
      update(32'h200, 1'b1, 1'b0, 1'b1, 32'h88);
      lookup(32'h200);
      expect_pred("alias_new", 1'b1, 1'b1, 32'h88);
      lookup(32'h100);
      check("alias_old.hit", {31'd0, bp_if.pred_hit}, 32'd0);

      // Jump at 0x80 predicts taken even with the counter driven to 0.
      update(32'h80, 1'b0, 1'b1, 1'b1, 32'h300);
      update(32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
      update(32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
      lookup(32'h80);
      expect_pred("jump", 1'b1, 1'b1, 32'h300);

      // Stall freezes outputs; flush overrides stall.
      bp_if.stall = 1'b1;
      lookup(32'h200);
      expect_pred("stall", 1'b1, 1'b1, 32'h300);
      bp_if.flush = 1'b1;
      step();
      check("flush.hit", {31'd0, bp_if.pred_hit}, 32'd0);
      check("flush.taken", {31'd0, bp_if.pred_taken}, 32'd0);
      bp_if.stall = 1'b0;
      bp_if.flush = 1'b0;

      // Same-cycle lookup and allocate: read before write.
      bp_if.lookup_pc = 32'h100;
      update(32'h100, 1'b1, 1'b0, 1'b1, 32'h44);
      check("rbw.hit", {31'd0, bp_if.pred_hit}, 32'd0);
      lookup(32'h100);
      expect_pred("rbw_next", 1'b1, 1'b1, 32'h44);

      // Update commits alongside flush.
      bp_if.flush = 1'b1;
      update(32'hC0, 1'b1, 1'b0, 1'b1, 32'h10);
      bp_if.flush = 1'b0;
      lookup(32'hC0);
      expect_pred("upd_flush", 1'b1, 1'b1, 32'h10);

      // Not-taken miss and non-control updates do not allocate.
      update(32'h180, 1'b1, 1'b0, 1'b0, 32'h20);
      update(32'h140, 1'b0, 1'b0, 1'b1, 32'h24);
      lookup(32'h180);
      check("nt_miss.hit", {31'd0, bp_if.pred_hit}, 32'd0);
      lookup(32'h140);
      check("no_ctrl.hit", {31'd0, bp_if.pred_hit}, 32'd0);

      // Asynchronous reset mid-run clears outputs at once and empties the table.
      lookup(32'h100);
      reset = 1'b0;
      #1;
      expect_pred("async_rst", 1'b0, 1'b0, 32'h0);
      step();
      reset = 1'b1;
      lookup(32'h100);
      expect_pred("post_rst", 1'b0, 1'b0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
